// File: rtl/vec_pkg.sv
// Shared types and constants for the vector load-writeback sequencer.
// Optional VRF byte-enable masking is controlled by macro VEC_WB_MASK_EN.
package vec_pkg;

    localparam int VLEN       = 512;
    localparam int SEW        = 32;
    localparam int VLMAX      = 16;
    localparam int MAX_VLEN   = 4096;
    localparam int BEAT_ELEMS = 4;
    localparam int VL_W       = 5;
    localparam int NBEATS     = VLMAX / BEAT_ELEMS;
    localparam int BEAT_W     = $clog2(NBEATS);
    localparam int EIDX_W     = $clog2(VLMAX);
    localparam int BEAT_BITS  = BEAT_ELEMS * SEW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } wb_state_e;

    function automatic logic [VL_W-1:0] clip_vl(input logic [VL_W-1:0] v);
        return (v > VL_W'(VLMAX)) ? VL_W'(VLMAX) : v;
    endfunction

    // Index of the final beat; only meaningful when vl_eff is non-zero.
    function automatic logic [BEAT_W-1:0] last_beat(input logic [VL_W-1:0] vl_eff);
        return BEAT_W'((vl_eff + VL_W'(BEAT_ELEMS - 1)) / VL_W'(BEAT_ELEMS) - VL_W'(1));
    endfunction

endpackage

// File: rtl/vec_wb_beat_sel.sv
// Beat slicer: picks one element group from the captured register,
// builds per-element enables from vl and mask, and zeroes disabled data.
module vec_wb_beat_sel
    import vec_pkg::*;
(
    input  logic [VLEN-1:0]       i_data,
    input  logic [BEAT_W-1:0]     i_beat,
    input  logic [VL_W-1:0]       i_vl,
    input  logic [VLMAX-1:0]      i_mask,
    input  logic                  i_en,
    output logic [BEAT_BITS-1:0]  o_data,
    output logic [BEAT_ELEMS-1:0] o_be
);

    genvar j;
    for (j = 0; j < BEAT_ELEMS; j++) begin : g_el
        logic [VL_W-1:0] w_idx;

        assign w_idx = VL_W'(i_beat) * VL_W'(BEAT_ELEMS) + VL_W'(j);
        assign o_be[j] = i_en && (w_idx < i_vl) && i_mask[w_idx[EIDX_W-1:0]];
        assign o_data[j*SEW +: SEW] =
            o_be[j] ? i_data[int'(w_idx)*SEW +: SEW] : '0;
    end

endmodule

// File: rtl/vec_ld_wb.sv
// Vector load-writeback sequencer: captures an LSU result and streams it
// into the VRF beat by beat. Optional v0 masking via macro VEC_WB_MASK_EN.
module vec_ld_wb
    import vec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MAX_VLEN-1:0]   lsu2wb_data,
    input  logic                  lsu2wb_valid,
    input  logic [4:0]            vd_addr,
    input  logic [VL_W-1:0]       vl,
`ifdef VEC_WB_MASK_EN
    input  logic [VLMAX-1:0]      v0_mask,
`endif
    output logic [4:0]            wb2vrf_addr,
    output logic [BEAT_W-1:0]     wb2vrf_beat,
    output logic [BEAT_BITS-1:0]  wb2vrf_data,
    output logic [BEAT_ELEMS-1:0] wb2vrf_be,
    output logic                  wb2vrf_valid,
    input  logic                  vrf2wb_ready,
    output logic                  wb_busy,
    output logic                  wb_done
);

    wb_state_e         r_state;
    logic              r_valid_q;
    logic [VLEN-1:0]   r_data;
    logic [4:0]        r_addr;
    logic [VL_W-1:0]   r_vl;
    logic [BEAT_W-1:0] r_last;
    logic [BEAT_W-1:0] r_beat;

    logic              w_cap;
    logic [VL_W-1:0]   w_vl_eff;
    logic [VLMAX-1:0]  w_mask;
    logic              w_unused;

    // Upper LSU bus bits belong to wider configurations and are ignored.
    assign w_unused = ^lsu2wb_data[MAX_VLEN-1:VLEN];

    assign w_vl_eff = clip_vl(vl);
    assign w_cap    = (r_state == IDLE) && lsu2wb_valid && !r_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_valid_q <= 1'b0;
            r_data    <= '0;
            r_addr    <= '0;
            r_vl      <= '0;
            r_last    <= '0;
            r_beat    <= '0;
        end else begin
            r_valid_q <= lsu2wb_valid;
            unique case (r_state)
                IDLE: begin
                    if (w_cap) begin
                        r_data  <= lsu2wb_data[VLEN-1:0];
                        r_addr  <= vd_addr;
                        r_vl    <= w_vl_eff;
                        r_last  <= last_beat(w_vl_eff);
                        r_beat  <= '0;
                        r_state <= (w_vl_eff == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (vrf2wb_ready) begin
                        if (r_beat == r_last) begin
                            r_state <= DONE;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef VEC_WB_MASK_EN
    logic [VLMAX-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_cap) begin
            r_mask <= v0_mask;
        end
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    assign wb2vrf_valid = (r_state == WRITE);
    assign wb_busy      = (r_state != IDLE);
    assign wb_done      = (r_state == DONE);
    assign wb2vrf_addr  = r_addr;
    assign wb2vrf_beat  = r_beat;

    vec_wb_beat_sel u_sel (
        .i_data (r_data),
        .i_beat (r_beat),
        .i_vl   (r_vl),
        .i_mask (w_mask),
        .i_en   (wb2vrf_valid),
        .o_data (wb2vrf_data),
        .o_be   (wb2vrf_be)
    );

endmodule

// File: tb/tb_vec_ld_wb.sv
// Scoreboard bench for vec_ld_wb: stimulus pushes expected beats/done,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vec_ld_wb;

    logic          clk;
    logic          rst;
    logic [4095:0] lsu2wb_data;
    logic          lsu2wb_valid;
    logic [4:0]    vd_addr;
    logic [4:0]    vl;
    logic [15:0]   v0_mask;
    logic [4:0]    wb2vrf_addr;
    logic [1:0]    wb2vrf_beat;
    logic [127:0]  wb2vrf_data;
    logic [3:0]    wb2vrf_be;
    logic          wb2vrf_valid;
    logic          vrf2wb_ready;
    logic          wb_busy;
    logic          wb_done;

    vec_ld_wb dut (
        .clk          (clk),
        .rst          (rst),
        .lsu2wb_data  (lsu2wb_data),
        .lsu2wb_valid (lsu2wb_valid),
        .vd_addr      (vd_addr),
        .vl           (vl),
`ifdef VEC_WB_MASK_EN
        .v0_mask      (v0_mask),
`endif
        .wb2vrf_addr  (wb2vrf_addr),
        .wb2vrf_beat  (wb2vrf_beat),
        .wb2vrf_data  (wb2vrf_data),
        .wb2vrf_be    (wb2vrf_be),
        .wb2vrf_valid (wb2vrf_valid),
        .vrf2wb_ready (vrf2wb_ready),
        .wb_busy      (wb_busy),
        .wb_done      (wb_done)
    );

    typedef struct {
        logic [4:0]   a;
        logic [1:0]   b;
        logic [127:0] d;
        logic [3:0]   be;
        int           c;
    } exp_t;

    exp_t beat_q[$];
    int   done_q[$];
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   n_stable;

    bit           stall;
    logic [4:0]   s_addr;
    logic [1:0]   s_beat;
    logic [127:0] s_data;
    logic [3:0]   s_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    function automatic logic [31:0] elem(input logic [15:0] seed, input int i);
        return {seed, 8'hC0, 8'(i)};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                n_stable++;
                chk("stall_valid", 128'(wb2vrf_valid), 128'(1));
                chk("stall_addr", 128'(wb2vrf_addr), 128'(s_addr));
                chk("stall_beat", 128'(wb2vrf_beat), 128'(s_beat));
                chk("stall_data", wb2vrf_data, s_data);
                chk("stall_be", 128'(wb2vrf_be), 128'(s_be));
            end
            if (wb2vrf_valid && vrf2wb_ready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 128'(wb2vrf_beat), 128'(7));
                end else begin
                    exp_t e;
                    e = beat_q.pop_front();
                    chk("beat_addr", 128'(wb2vrf_addr), 128'(e.a));
                    chk("beat_idx", 128'(wb2vrf_beat), 128'(e.b));
                    chk("beat_data", wb2vrf_data, e.d);
                    chk("beat_be", 128'(wb2vrf_be), 128'(e.be));
                    if (e.c >= 0) chk("beat_cycle", 128'(cyc), 128'(e.c));
                end
            end
            if (wb_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 128'(1), 128'(0));
                end else begin
                    int dc;
                    dc = done_q.pop_front();
                    if (dc >= 0) chk("done_cycle", 128'(cyc), 128'(dc));
                    else chk("done_seen", 128'(wb_done), 128'(1));
                end
            end
            stall  = wb2vrf_valid && !vrf2wb_ready;
            s_addr = wb2vrf_addr;
            s_beat = wb2vrf_beat;
            s_data = wb2vrf_data;
            s_be   = wb2vrf_be;
        end
    end

    // Raise lsu2wb_valid and push the expected writeback sequence.
    task automatic start(input logic [4:0] vd, input logic [4:0] vlv,
                         input int nb, input logic [3:0] be_full,
                         input logic [3:0] be_last, input int npush,
                         input bit timed, input logic [15:0] seed,
                         input logic [15:0] mask);
        logic [4095:0] d;
        int c0;
        @(posedge clk);
        #2;
        d = '1;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = elem(seed, i);
        lsu2wb_data  = d;
        vd_addr      = vd;
        vl           = vlv;
        v0_mask      = mask;
        lsu2wb_valid = 1'b1;
        c0 = cyc;
        for (int b = 0; b < npush; b++) begin
            exp_t e;
            e.a  = vd;
            e.b  = 2'(b);
            e.be = (b == nb - 1) ? be_last : be_full;
            e.d  = '0;
            for (int j = 0; j < 4; j++)
                if (e.be[j]) e.d[j*32 +: 32] = elem(seed, b*4 + j);
            e.c  = timed ? c0 + 1 + b : -1;
            beat_q.push_back(e);
        end
        if (npush == nb) done_q.push_back(timed ? c0 + 1 + nb : -1);
    endtask

    task automatic drop();
        @(posedge clk);
        #2;
        lsu2wb_valid = 1'b0;
        vd_addr      = 5'h1F;
        vl           = 5'd0;
        v0_mask      = 16'h0;
        lsu2wb_data  = '0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (!wb_busy && beat_q.size() == 0 && done_q.size() == 0) ok = 1'b1;
        end
        chk(nm, 128'(ok), 128'(1));
        beat_q.delete();
        done_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        n_stable     = 0;
        stall        = 1'b0;
        rst          = 1'b1;
        lsu2wb_data  = '0;
        lsu2wb_valid = 1'b0;
        vd_addr      = '0;
        vl           = '0;
        v0_mask      = '0;
        vrf2wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 128'(wb2vrf_valid), 128'(0));
        chk("rst_busy", 128'(wb_busy), 128'(0));
        chk("rst_done", 128'(wb_done), 128'(0));
        chk("rst_be", 128'(wb2vrf_be), 128'(0));
        chk("rst_data", wb2vrf_data, 128'(0));
        chk("rst_addr", 128'(wb2vrf_addr), 128'(0));

        // full register, 4 beats back to back
        start(5'd3, 5'd16, 4, 4'hF, 4'hF, 4, 1'b1, 16'h1111, 16'hFFFF);
        drop();
        wait_idle("idle_t1");

        // vl=6: second beat only has elements 4,5
        start(5'd7, 5'd6, 2, 4'hF, 4'b0011, 2, 1'b1, 16'h2222, 16'hFFFF);
        drop();
        wait_idle("idle_t2");

        // vl=0: straight to done
        start(5'd9, 5'd0, 0, 4'hF, 4'hF, 0, 1'b1, 16'h3333, 16'hFFFF);
        drop();
        wait_idle("idle_t3a");

        // vl=20 clipped to 16
        start(5'd10, 5'd20, 4, 4'hF, 4'hF, 4, 1'b1, 16'h4444, 16'hFFFF);
        drop();
        wait_idle("idle_t3b");

        // VRF stalls beat1 for three cycles
        start(5'd12, 5'd16, 4, 4'hF, 4'hF, 4, 1'b0, 16'h5555, 16'hFFFF);
        n_stable = 0;
        drop();
        @(posedge clk);
        #2 vrf2wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 vrf2wb_ready = 1'b1;
        wait_idle("idle_t4");
        chk("stall_cycles", 128'(n_stable), 128'(3));

        // level held six cycles: one sequence only
        start(5'd14, 5'd16, 4, 4'hF, 4'hF, 4, 1'b1, 16'h6666, 16'hFFFF);
        repeat (5) @(posedge clk);
        drop();
        wait_idle("idle_t5a");

        // second rising edge during WRITE is ignored
        start(5'd15, 5'd16, 4, 4'hF, 4'hF, 4, 1'b1, 16'h7777, 16'hFFFF);
        drop();
        @(posedge clk);
        #2 lsu2wb_valid = 1'b1;
        @(posedge clk);
        #2 lsu2wb_valid = 1'b0;
        wait_idle("idle_t5b");
        repeat (4) @(negedge clk);
        chk("no_recapture", 128'(wb_busy), 128'(0));

        // reset while beat2 is pending
        start(5'd17, 5'd16, 4, 4'hF, 4'hF, 2, 1'b1, 16'h8888, 16'hFFFF);
        drop();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        vrf2wb_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        vrf2wb_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 128'(wb2vrf_valid), 128'(0));
        chk("mid_rst_busy", 128'(wb_busy), 128'(0));
        chk("mid_rst_done", 128'(wb_done), 128'(0));
        chk("mid_rst_queue", 128'(beat_q.size()), 128'(0));
        start(5'd18, 5'd16, 4, 4'hF, 4'hF, 4, 1'b1, 16'h9999, 16'hFFFF);
        drop();
        wait_idle("idle_t6");

`ifdef VEC_WB_MASK_EN
        start(5'd20, 5'd16, 4, 4'b1010, 4'b1010, 4, 1'b1, 16'hAAAA, 16'hAAAA);
        drop();
        wait_idle("idle_mask");
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
